// File: rtl/hash_engine.sv
// Iterative hash engine: absorbs W-bit message bytes over valid/ready and applies
// NUM_ROUNDS rounds per byte, one per clock; the final 4W-bit state is the digest.
module hash_engine #(
  parameter int               W          = 8,
  parameter int               NUM_ROUNDS = 8,
  parameter logic [4*W-1:0]   IV         = 'h6745_2301
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_digest
);
  localparam int            RW     = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t                fsm;
  logic [3:0][W-1:0]   lanes;      // {d,c,b,a}, a in lane 0
  logic [3:0][W-1:0]   lanes_nxt;
  logic [RW-1:0]       rnd;
  logic [W-1:0]        msg;
  logic                last;

  // Round function for the current round index applied to the latched byte.
  always_comb begin
    logic [W-1:0]   a, b, c, d, mix, t;
    logic [2*W-1:0] rot;
    int             k, sh;
    a   = lanes[0];
    b   = lanes[1];
    c   = lanes[2];
    d   = lanes[3];
    k   = int'(rnd) % 8;
    sh  = int'(rnd) % W;
    case (k)
      0, 1, 2: mix = (c & b) | (~b & d);
      3, 4:    mix = (c & b) | (b & d) | (c & d);
      default: mix = c ^ b ^ d;
    endcase
    t   = mix + a + msg;
    // Upper half of the doubled word shifted left is the left rotation by sh.
    rot = {t, t} << sh;
    lanes_nxt = {c, b, rot[2*W-1:W], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm   <= IDLE;
      lanes <= IV;
      rnd   <= '0;
      msg   <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      fsm   <= IDLE;
      lanes <= IV;
      rnd   <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          msg  <= in_data;
          last <= in_last;
          rnd  <= '0;
          fsm  <= ROUND;
        end
        ROUND: begin
          lanes <= lanes_nxt;
          if (rnd == R_LAST) begin
            rnd <= '0;
            fsm <= last ? DONE : IDLE;
          end else begin
            rnd <= rnd + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          lanes <= IV;
          fsm   <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready   = (fsm == IDLE);
  assign out_valid  = (fsm == DONE);
  assign out_digest = lanes;

endmodule

// File: doc/hash_engine.md
# hash_engine

Iterative, parametrised successor to the single-stage hash round. It absorbs a stream of W-bit message bytes over a valid/ready handshake and applies NUM_ROUNDS rounds per byte, one round per clock, to a 4W-bit chaining state. On the byte flagged last it presents the final state as the digest on a valid/ready output port. It sits between the message source (e.g. keypad/password buffer) and the digest comparator.

## Interface

- W, 8: width of a message byte and of each state lane; state and digest are 4W bits.
- NUM_ROUNDS, 8: rounds applied to each byte; must be ≥1.
- IV, 32'h6745_2301: initial state ({d,c,b,a}, a in LSBs); width 4W.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous abort: state←IV, FSM←IDLE
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  engine can accept a byte
- in_data  in  W  message byte
- in_last  in  1  marks the final byte of the message
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts the digest
- out_digest  out  4W  final state, held stable while out_valid

## Operation

- State packing: {d,c,b,a} = state, with a in bits [W-1:0].
- Round r (r = 0..NUM_ROUNDS-1), with k = r mod 8:
  - k∈{0,1,2}: mix = (c&b)|(~b&d)
  - k∈{3,4}: mix = (c&b)|(b&d)|(c&d)
  - k∈{5,6,7}: mix = c^b^d
  - t = (mix + a + byte) mod 2^W; a' = t rotated left by (r mod W).
  - next state {d,c,b,a} ← {c, b, a', d}.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_last, r←0 → ROUND.
  - ROUND: apply round r each cycle. If r==NUM_ROUNDS-1 → DONE when the latched last flag is set, else → IDLE; otherwise r←r+1.
  - DONE: out_valid=1, out_digest=state. On out_ready, state←IV → IDLE.
- The round counter is $clog2(NUM_ROUNDS) bits, minimum 1 bit.
- clear has priority over every other event in every state. A byte offered in the same cycle as clear is not accepted.
- Reset values: FSM=IDLE, state=IV, r=0, in_ready=1 (combinational from IDLE), out_valid=0. out_digest reflects state, i.e. IV.
- Reset or clear mid-message or mid-round discards all progress. No partial digest is ever emitted.

## Timing

- Byte accepted at edge E. Rounds update state at edges E+1..E+NUM_ROUNDS.
- in_ready is high again in the cycle after edge E+NUM_ROUNDS. Throughput is one byte per NUM_ROUNDS+1 cycles with in_valid held high.
- For a last byte, out_valid rises after edge E+NUM_ROUNDS and stays high until the edge where out_ready=1.
- in_ready is 0 throughout ROUND and DONE. in_data and in_last are ignored there.
- out_ready is ignored when out_valid=0.
- in_ready and out_valid are decoded from FSM state only and have no combinational path from inputs.

## Test plan

- Reset: assert reset asynchronously mid-cycle → out_valid=0, in_ready=1, out_digest=32'h67452301 immediately, without waiting for a clock edge.
- NUM_ROUNDS=1, W=8: byte 8'h00 with last=1 → out_valid exactly 2 cycles after acceptance, out_digest=32'h45234667.
- NUM_ROUNDS=2: byte 8'h00 with last=1 → out_digest=32'h2346D445, out_valid 3 cycles after acceptance.
- Defaults: stream 3 bytes back-to-back with in_valid held high → acceptances exactly 9 cycles apart. Digest matches the bench model and holds through 5 cycles of out_ready=0. On out_ready the engine returns to IDLE and the next message starts from IV.
- clear asserted during round 4 of a byte with in_valid=1 → next cycle IDLE, state=IV, byte not accepted, no out_valid. A subsequent 1-byte message yields the same digest as on a fresh reset.
- Random sweep over W∈{8,16} and NUM_ROUNDS∈{1,5,8,12}, with random in_valid/out_ready stalls → every digest matches the reference model and no handshake is dropped or duplicated.
